// File: rtl/key_event_classifier_pkg.sv
// Shared types for the key event classifier.
//   state_t  : FSM state encoding (IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, HELD=4)
//   pulse_t  : bundle of the four one-clock event pulses
//   is_active: true for every state other than IDLE (drives busy)
package key_event_classifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_HELD   = 3'd4
    } state_t;

    typedef struct packed {
        logic short_p;
        logic long_p;
        logic repeat_p;
        logic double_p;
    } pulse_t;

    function automatic logic is_active(input state_t s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/key_event_classifier_if.sv
// Signal bundle between the debouncer side and the alarm-clock control FSM.
//   key_db       : debounced key level, 1 = pressed
//   short_pulse  : single short press confirmed
//   long_pulse   : press held long enough to count as long
//   repeat_pulse : periodic pulse while still held after long
//   double_pulse : second press arrived within the double-click window
//   busy         : classifier FSM is not idle
// master drives the key and observes events; slave is the classifier.
interface key_event_classifier_if;
    logic key_db;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic double_pulse;
    logic busy;

    modport master (
        output key_db,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  double_pulse,
        input  busy
    );

    modport slave (
        input  key_db,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output double_pulse,
        output busy
    );
endinterface

// File: rtl/key_event_classifier_tick_gen.sv
// Free-running clock divider producing a one-clock tick every CLK_DIV clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (divider returns to 0)
//   tick  : high for one clock while the divider sits at CLK_DIV-1
module tick_gen #(
    parameter int CLK_DIV = 100000,
    parameter int DIV_W   = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign tick = (div_q == DIV_LAST);

endmodule

// File: rtl/key_event_classifier.sv
// Classifies debounced key presses into short / long (+auto-repeat) /
// double-click events, reported as registered one-clock pulses.
//   clk   : system clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset
//   evt   : slave side of key_event_classifier_if (key_db in; pulses, busy out)
//
// state  | meaning
// IDLE   | key released, nothing pending
// PRESS1 | first press in progress, timing towards long
// WAIT2  | first press released, watching for a second press
// PRESS2 | second press of a double-click, waiting for release
// HELD   | long press confirmed, emitting repeats while held
module key_event_classifier #(
    parameter int CLK_DIV   = 100000,
    parameter int DIV_W     = 17,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int DOUBLE_MS = 300,
    parameter int CNT_W     = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    key_event_classifier_if.slave  evt
);

    import key_event_classifier_pkg::*;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);
    localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_MS - 1);

    logic             key_q;
    logic             rise;
    logic             fall;
    logic             tick;
    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             rep_clr;
    pulse_t           pulse_d;
    pulse_t           pulse_q;
    logic             busy_q;

    // key_q resets to 0 so a key already down at reset release is seen as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= 1'b0;
        end else begin
            key_q <= evt.key_db;
        end
    end

    assign rise = evt.key_db & ~key_q;
    assign fall = ~evt.key_db & key_q;

    tick_gen #(
        .CLK_DIV (CLK_DIV),
        .DIV_W   (DIV_W)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Key edges are tested before the tick threshold so a release (or second
    // press) on the threshold clock takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        rep_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                end
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_WAIT2;
                end else if (tick && (cnt_q == LONG_LAST)) begin
                    state_d        = ST_HELD;
                    pulse_d.long_p = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (rise) begin
                    state_d          = ST_PRESS2;
                    pulse_d.double_p = 1'b1;
                end else if (tick && (cnt_q == DOUBLE_LAST)) begin
                    state_d         = ST_IDLE;
                    pulse_d.short_p = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end else if (tick && (cnt_q == REPEAT_LAST)) begin
                    pulse_d.repeat_p = 1'b1;
                    rep_clr          = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Tick counter restarts on every state change, so each threshold is
    // measured from state entry with -1/+0 tick resolution.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if ((state_d != state_q) || rep_clr) begin
            cnt_q <= '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // busy is registered from the next state so it lines up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            busy_q  <= is_active(state_d);
        end
    end

    assign evt.short_pulse  = pulse_q.short_p;
    assign evt.long_pulse   = pulse_q.long_p;
    assign evt.repeat_pulse = pulse_q.repeat_p;
    assign evt.double_pulse = pulse_q.double_p;
    assign evt.busy         = busy_q;

endmodule

// File: tb/tb_key_event_classifier.sv
module tb_key_event_classifier;

    logic clk;
    logic rst_n;

    key_event_classifier_if bus ();

    key_event_classifier #(
        .CLK_DIV   (4),
        .DIV_W     (17),
        .LONG_MS   (10),
        .REPEAT_MS (3),
        .DOUBLE_MS (5),
        .CNT_W     (11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release; with CLK_DIV=4 the tick is sampled on
    // every edge whose index is a multiple of 4.
    int edge_n;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    int n_checks;
    int n_errors;
    int n_short, n_long, n_rep, n_dbl;
    int e_first;
    int onehot_bad;
    int cons_bad;

    typedef struct {
        int p1;
        int gap;
        int p2;
        int x_short;
        int x_long;
        int x_rep;
        int x_dbl;
        int x_first;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic clear_counts();
        n_short = 0;
        n_long  = 0;
        n_rep   = 0;
        n_dbl   = 0;
        e_first = -1;
    endtask

    // Drive the key for one clock and record what the outputs show after the edge.
    task automatic cyc(input logic k);
        logic [3:0] p;
        bus.key_db = k;
        @(posedge clk);
        #1;
        p = {bus.short_pulse, bus.long_pulse, bus.repeat_pulse, bus.double_pulse};
        if (p != 4'b0 && e_first < 0) e_first = edge_n;
        if (bus.short_pulse)  n_short++;
        if (bus.long_pulse)   n_long++;
        if (bus.repeat_pulse) n_rep++;
        if (bus.double_pulse) n_dbl++;
        if ($countones(p) > 1) onehot_bad++;
        if (bus.short_pulse && bus.busy) cons_bad++;
        if ((bus.long_pulse || bus.repeat_pulse || bus.double_pulse) && !bus.busy) cons_bad++;
    endtask

    task automatic hold(input logic k, input int n);
        for (int i = 0; i < n; i++) cyc(k);
    endtask

    task automatic align();
        for (int i = 0; i < 8 && (edge_n % 4) != 0; i++) cyc(1'b0);
    endtask

    task automatic run_row(input vec_t v, input int idx);
        int e0;
        align();
        clear_counts();
        e0 = edge_n + 1;
        cyc(1'b1);
        chk($sformatf("row%0d busy_after_press", idx), int'(bus.busy), 1);
        hold(1'b1, v.p1 - 1);
        if (v.p2 > 0) begin
            hold(1'b0, v.gap);
            hold(1'b1, v.p2);
        end
        hold(1'b0, 70);
        chk($sformatf("row%0d short_count", idx),  n_short, v.x_short);
        chk($sformatf("row%0d long_count", idx),   n_long,  v.x_long);
        chk($sformatf("row%0d repeat_count", idx), n_rep,   v.x_rep);
        chk($sformatf("row%0d double_count", idx), n_dbl,   v.x_dbl);
        chk($sformatf("row%0d first_pulse_offset", idx), e_first - e0, v.x_first);
        chk($sformatf("row%0d busy_idle", idx), int'(bus.busy), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        logic lvl;

        n_checks   = 0;
        n_errors   = 0;
        onehot_bad = 0;
        cons_bad   = 0;
        clear_counts();

        // p1, gap, p2, short, long, repeat, double, first-pulse offset from press edge
        vecs[0]  = '{1,  0,  0,  1, 0, 0, 0, 19};
        vecs[1]  = '{8,  0,  0,  1, 0, 0, 0, 27};
        vecs[2]  = '{80, 0,  0,  0, 1, 3, 0, 39};
        vecs[3]  = '{40, 0,  0,  0, 1, 0, 0, 39};
        vecs[4]  = '{39, 0,  0,  1, 0, 0, 0, 59};
        vecs[5]  = '{38, 0,  0,  1, 0, 0, 0, 55};
        vecs[6]  = '{8,  8,  8,  0, 0, 0, 1, 16};
        vecs[7]  = '{8,  19, 8,  0, 0, 0, 1, 27};
        vecs[8]  = '{8,  18, 8,  0, 0, 0, 1, 26};
        vecs[9]  = '{8,  20, 8,  2, 0, 0, 0, 27};
        vecs[10] = '{8,  8,  60, 0, 0, 0, 1, 16};

        rst_n      = 1'b0;
        bus.key_db = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset short",  int'(bus.short_pulse),  0);
        chk("reset long",   int'(bus.long_pulse),   0);
        chk("reset repeat", int'(bus.repeat_pulse), 0);
        chk("reset double", int'(bus.double_pulse), 0);
        chk("reset busy",   int'(bus.busy),         0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 11; r++) run_row(vecs[r], r);

        // Reset asserted mid-cycle while a repeat pulse is showing.
        align();
        clear_counts();
        e0 = edge_n + 1;
        hold(1'b1, 52);
        chk("held repeat before reset", int'(bus.repeat_pulse), 1);
        chk("held long count before reset", n_long, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset repeat", int'(bus.repeat_pulse), 0);
        chk("async reset busy",   int'(bus.busy),         0);
        chk("async reset long",   int'(bus.long_pulse),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Key still down at reset release counts as a fresh press on edge 1.
        clear_counts();
        e0 = 1;
        hold(1'b1, 45);
        chk("post reset long count",  n_long, 1);
        chk("post reset long offset", e_first - e0, 39);
        chk("post reset repeat none", n_rep, 0);
        hold(1'b0, 70);
        chk("post reset busy idle", int'(bus.busy), 0);

        // Random key activity: pulses stay one-hot and agree with busy.
        clear_counts();
        onehot_bad = 0;
        cons_bad   = 0;
        lvl        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            lvl = ~lvl;
            hold(lvl, int'($urandom_range(1, 50)));
        end
        hold(1'b0, 70);
        chk("random one-hot violations", onehot_bad, 0);
        chk("random busy consistency",   cons_bad,   0);
        chk("random busy idle",          int'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_event_classifier.md
Name: key_event_classifier

Overview:
- Sits directly downstream of the key debouncer. Consumes one debounced, active-high key level.
- Classifies each press as short, long (with auto-repeat while held) or double-click.
- Emits one-clock pulses that the alarm-clock control FSM uses for set/increment/mode actions.
- Timing is measured in 1 ms ticks generated internally from the 100 MHz system clock.

Parameters:
- CLK_DIV, 100000, system clocks per 1 ms tick (100 MHz -> 1 kHz).
- DIV_W, 17, divider counter width; must hold CLK_DIV-1.
- LONG_MS, 1000, ticks held before a press counts as long.
- REPEAT_MS, 200, ticks between repeat pulses while held after long.
- DOUBLE_MS, 300, max ticks from first release to second press for a double-click.
- CNT_W, 11, tick counter width; must hold max(LONG_MS, REPEAT_MS, DOUBLE_MS).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_db  input  1  debounced key level from the debouncer, 1 = pressed.
- short_pulse  output  1  one-clock pulse: single short press confirmed.
- long_pulse  output  1  one-clock pulse: press held LONG_MS ticks.
- repeat_pulse  output  1  one-clock pulse every REPEAT_MS ticks while still held after long.
- double_pulse  output  1  one-clock pulse: second press within DOUBLE_MS of first release.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset:
- state=IDLE; key_q=0; tick divider=0; tick counter=0.
- All pulse outputs 0; busy 0.
- If key_db is high at reset release, a rise is detected on the first clock and treated as a new press. This is intentional.

Edge detect:
- key_q registers key_db.
- rise = key_db & ~key_q; fall = ~key_db & key_q.

Tick generation:
- Divider is free-running, 0..CLK_DIV-1.
- tick is asserted for one clock when the divider equals CLK_DIV-1.

Tick counter:
- Cleared on every state transition.
- Otherwise increments on tick, saturating at all-ones.
- Threshold resolution is therefore -1/+0 tick.

FSM states and transitions:
- IDLE: rise -> PRESS1.
- PRESS1:
  - fall -> WAIT2.
  - Else tick with counter == LONG_MS-1 -> HELD, assert long_pulse.
  - If fall and the threshold tick coincide, fall wins: no long_pulse, go to WAIT2.
- WAIT2:
  - rise -> PRESS2, assert double_pulse.
  - Else tick with counter == DOUBLE_MS-1 -> IDLE, assert short_pulse.
  - If rise and timeout coincide, rise wins: double_pulse only.
- PRESS2: fall -> IDLE. No long or repeat detection on the second press.
- HELD:
  - fall -> IDLE, no pulse.
  - Else tick with counter == REPEAT_MS-1: assert repeat_pulse, clear counter, stay in HELD.

Outputs:
- All pulse outputs are registered: high for exactly one clock, in the cycle after the triggering event's edge.
- At most one pulse is high in any cycle.
- busy is registered and follows the state.
- A short press reports with latency DOUBLE_MS ticks after release, the cost of double-click detection.

Reset mid-operation:
- Any state returns to IDLE immediately; pending pulses are dropped.

Decomposition:
- Shared header key_event_defs.vh: 3-bit state encodings IDLE=0, PRESS1=1, WAIT2=2, PRESS2=3, HELD=4. Unused codes decode to IDLE.
- Sub-module tick_gen(CLK_DIV, DIV_W): free-running divider with a tick output, async active-low reset.
- Edge detect, FSM and tick counter remain in the top module.

Test Plan (CLK_DIV=4, LONG_MS=10, REPEAT_MS=3, DOUBLE_MS=5, clk 10 ns):
1. Short press: key_db high 5 ticks, then low and held low -> exactly one short_pulse, 4-5 ticks after release; no other pulse; busy drops the same cycle.
2. Long press with repeat: key_db high 20 ticks -> long_pulse at ~10 ticks, then repeat_pulse at ~13, 16, 19; release -> no further pulses, busy=0.
3. Double-click: press 2 ticks, release 2 ticks, press 2 ticks, release -> one double_pulse on the second rise (+1 clk); no short_pulse; state IDLE after the second release.
4. Boundary race: release on the same clock as the LONG threshold tick -> no long_pulse; short_pulse after DOUBLE_MS. Second press on the same clock as the WAIT2 timeout tick -> double_pulse only.
5. Reset mid-HELD: assert rst_n=0 during the repeat phase -> all outputs 0 asynchronously. Release reset with key_db=1 -> treated as a new press; long_pulse ~10 ticks later.
6. One-hot check: randomized key_db with 200 events -> never more than one pulse output high in any cycle; busy==(state!=IDLE) throughout.
